// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory port arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DBG_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  localparam int DEFAULT_STARVE_LIMIT = 8;
  localparam int DEFAULT_TIMEOUT      = 255;

  // BUSY state that serves a given owner
  function automatic arb_state_e busy_state(input owner_e owner);
    return (owner == OWNER_DBG) ? DBG_BUSY : CPU_BUSY;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/debug arbiter and sequencer for the shared data-memory port (optional timeout: DMEM_ARB_TIMEOUT_EN)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  output logic          dbg_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("dmem_port_arbiter: STARVE_LIMIT must be >= 1 and TIMEOUT in 1..255");
  end

  arb_state_e      state_q;
  logic [SC_W-1:0] starve_cnt_q;
  logic            cpu_elig;
  logic            dbg_elig;
  logic            dbg_waiting;
  logic            starved;
  logic            cpu_grant;
  logic            dbg_grant;
  owner_e          grant_owner;
  logic            grant_we;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_wdata;
  logic            abort;
  logic            finish;

  // A requester whose done pulse is showing this cycle has just been served
  // and must not be re-granted until its next request cycle.
  assign cpu_elig    = cpu_req & ~cpu_done;
  assign dbg_elig    = dbg_req & ~dbg_done;
  assign dbg_waiting = dbg_elig & (state_q != DBG_BUSY);
  assign starved     = starve_cnt_q >= SC_W'(STARVE_LIMIT);

  assign busy      = (state_q != IDLE);
  assign dbg_grant = ~busy & dbg_elig & (starved | ~cpu_elig);
  assign cpu_grant = ~busy & cpu_elig & ~dbg_grant;

  assign grant_owner = dbg_grant ? OWNER_DBG : OWNER_CPU;
  assign grant_we    = dbg_grant ? dbg_we    : cpu_we;
  assign grant_addr  = dbg_grant ? dbg_addr  : cpu_addr;
  assign grant_wdata = dbg_grant ? dbg_wdata : cpu_wdata;

  assign finish    = busy & (mem_ready | abort);
  assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt_q;
  logic       cpu_err_q;
  logic       dbg_err_q;

  // mem_ready on the terminal cycle still completes normally
  assign abort = busy & ~mem_ready & (to_cnt_q == TO_LAST);

  // Wait-cycle counter: zero while idle so every access starts from 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= 8'd0;
    end else if (!busy) begin
      to_cnt_q <= 8'd0;
    end else if (!mem_ready) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  // Error flags are registered alongside the done pulse they qualify
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_err_q <= 1'b0;
      dbg_err_q <= 1'b0;
    end else begin
      cpu_err_q <= abort & (state_q == CPU_BUSY);
      dbg_err_q <= abort & (state_q == DBG_BUSY);
    end
  end

  assign cpu_err = cpu_err_q;
  assign dbg_err = dbg_err_q;
`else
  assign abort   = 1'b0;
  assign cpu_err = 1'b0;
  assign dbg_err = 1'b0;
`endif

  // Starvation counter: counts cycles debug waits while not being served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (!dbg_waiting || dbg_grant) begin
      starve_cnt_q <= '0;
    end else if (!starved) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Arbitration FSM: latch the winner at grant, drive the port, return data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_grant || dbg_grant) begin
            state_q   <= busy_state(grant_owner);
            mem_en    <= 1'b1;
            mem_we    <= grant_we;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
          end
        end
        CPU_BUSY, DBG_BUSY: begin
          if (finish) begin
            state_q <= IDLE;
            mem_en  <= 1'b0;
            if (state_q == CPU_BUSY) begin
              cpu_done <= 1'b1;
              if (abort) begin
                cpu_rdata <= '0;
              end else if (!mem_we) begin
                cpu_rdata <= mem_rdata;
              end
            end else begin
              dbg_done <= 1'b1;
              if (abort) begin
                dbg_rdata <= '0;
              end else if (!mem_we) begin
                dbg_rdata <= mem_rdata;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          mem_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed vector bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam int NV = 20;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_err, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_done, dbg_err;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic cr; logic cw; logic [31:0] ca; logic [31:0] cwd;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dwd;
    logic rdy; logic [31:0] rdat;
    logic en; logic we; logic [31:0] addr; logic [31:0] wd;
    logic cd; logic [31:0] crd;
    logic dd; logic [31:0] drd;
    logic stall; logic bsy;
  } vec_t;

  vec_t tbl [NV];

  dmem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drain();
    dbg_req   = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (cpu_done) cpu_req = 1'b0;
      if (!busy && !cpu_req) break;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int arb;
    int bc;
    bit granted;

    checks = 0;
    failures = 0;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    //           cr cw ca          cwd           dr dw da          dwd    rdy rdat          en we addr        wd            cd crd           dd drd           st bsy
    tbl[0]  = '{L, L, 32'h0,     32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h0,        L, 32'h0,        L, L};
    tbl[1]  = '{H, L, 32'h100,   32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h0,        L, 32'h0,        H, L};
    tbl[2]  = '{H, L, 32'h100,   32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        H, L, 32'h100,   32'h0,        L, 32'h0,        L, 32'h0,        H, H};
    tbl[3]  = '{H, L, 32'h100,   32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        H, L, 32'h100,   32'h0,        L, 32'h0,        L, 32'h0,        H, H};
    tbl[4]  = '{H, L, 32'h100,   32'h0,        L, L, 32'h0,     32'h0, H, 32'hCAFEF00D, H, L, 32'h100,   32'h0,        L, 32'h0,        L, 32'h0,        H, H};
    tbl[5]  = '{H, L, 32'h100,   32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        H, 32'hCAFEF00D, L, 32'h0,        L, L};
    tbl[6]  = '{L, L, 32'h0,     32'h0,        L, L, 32'h0,     32'h0, H, 32'hBAD0BAD0, L, L, 32'h0,     32'h0,        L, 32'hCAFEF00D, L, 32'h0,        L, L};
    tbl[7]  = '{L, L, 32'h0,     32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'hCAFEF00D, L, 32'h0,        L, L};
    tbl[8]  = '{H, L, 32'h200,   32'h0,        H, L, 32'h300,   32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'hCAFEF00D, L, 32'h0,        H, L};
    tbl[9]  = '{H, L, 32'h200,   32'h0,        H, L, 32'h300,   32'h0, L, 32'h0,        H, L, 32'h200,   32'h0,        L, 32'hCAFEF00D, L, 32'h0,        H, H};
    tbl[10] = '{H, L, 32'h200,   32'h0,        H, L, 32'h300,   32'h0, H, 32'h11111111, H, L, 32'h200,   32'h0,        L, 32'hCAFEF00D, L, 32'h0,        H, H};
    tbl[11] = '{H, L, 32'h200,   32'h0,        H, L, 32'h300,   32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        H, 32'h11111111, L, 32'h0,        L, L};
    tbl[12] = '{L, L, 32'h0,     32'h0,        H, L, 32'h300,   32'h0, L, 32'h0,        H, L, 32'h300,   32'h0,        L, 32'h11111111, L, 32'h0,        L, H};
    tbl[13] = '{L, L, 32'h0,     32'h0,        H, L, 32'h300,   32'h0, H, 32'h22222222, H, L, 32'h300,   32'h0,        L, 32'h11111111, L, 32'h0,        L, H};
    tbl[14] = '{L, L, 32'h0,     32'h0,        H, L, 32'h300,   32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h11111111, H, 32'h22222222, L, L};
    tbl[15] = '{L, L, 32'h0,     32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h11111111, L, 32'h22222222, L, L};
    tbl[16] = '{H, H, 32'h400,   32'hA5A5A5A5, L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h11111111, L, 32'h22222222, H, L};
    tbl[17] = '{H, H, 32'h400,   32'hA5A5A5A5, L, L, 32'h0,     32'h0, H, 32'hDEADBEEF, H, H, 32'h400,   32'hA5A5A5A5, L, 32'h11111111, L, 32'h22222222, H, H};
    tbl[18] = '{H, H, 32'h400,   32'hA5A5A5A5, L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        H, 32'h11111111, L, 32'h22222222, L, L};
    tbl[19] = '{L, L, 32'h0,     32'h0,        L, L, 32'h0,     32'h0, L, 32'h0,        L, L, 32'h0,     32'h0,        L, 32'h11111111, L, 32'h22222222, L, L};

    // reset state
    #3;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cwd;
      dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dwd;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdat;
      #1;
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tbl[i].en});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("v%0d_cpu_stall", i), {31'd0, cpu_stall}, {31'd0, tbl[i].stall});
      chk($sformatf("v%0d_cpu_done", i), {31'd0, cpu_done}, {31'd0, tbl[i].cd});
      chk($sformatf("v%0d_dbg_done", i), {31'd0, dbg_done}, {31'd0, tbl[i].dd});
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].crd);
      chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, tbl[i].drd);
      chk($sformatf("v%0d_err", i), {30'd0, cpu_err, dbg_err}, 32'd0);
      if (tbl[i].en) begin
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].we});
        chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      end
    end

    // debug write: fields latched at grant, later changes ignored
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h2004; dbg_wdata = 32'h12345678;
    mem_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (b == 0) begin
        dbg_wdata = 32'h0BADF00D;
        dbg_we    = 1'b0;
      end
      #1;
      chk($sformatf("dw%0d_mem_en", b), {31'd0, mem_en}, 32'd1);
      chk($sformatf("dw%0d_mem_we", b), {31'd0, mem_we}, 32'd1);
      chk($sformatf("dw%0d_mem_addr", b), mem_addr, 32'h2004);
      chk($sformatf("dw%0d_mem_wdata", b), mem_wdata, 32'h12345678);
      if (b == 2) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h66666666;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("dw_done", {31'd0, dbg_done}, 32'd1);
    chk("dw_rdata_kept", dbg_rdata, 32'h22222222);
    dbg_req = 1'b0; dbg_we = 1'b0;

    // starvation: CPU requesting continuously, debug must still get in
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h700; dbg_wdata = 32'h0;
    mem_rdata = 32'h33333333; mem_ready = 1'b0;
    arb = 0; bc = 0; granted = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (mem_en && mem_addr == 32'h700) begin
        granted = 1'b1;
        break;
      end
      if (!busy) arb++;
      if (mem_en) bc++; else bc = 0;
      mem_ready = (bc >= 3);
      @(negedge clk);
    end
    chk("starve_granted", {31'd0, granted}, 32'd1);
    checks++;
    if (arb < 1 || arb > 9) begin
      failures++;
      $display("FAIL starve_arb_cycles actual=%0d expected=1..9", arb);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h44444444;
    @(negedge clk);
    #1;
    chk("starve_dbg_done", {31'd0, dbg_done}, 32'd1);
    chk("starve_dbg_rdata", dbg_rdata, 32'h44444444);
    drain();

    // hung memory: timeout abort, or indefinite wait without the feature
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; mem_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      #1;
      if (k == 16) begin
        chk("to_busy16", {31'd0, busy}, 32'd1);
        chk("to_nodone16", {31'd0, cpu_done}, 32'd0);
      end
    end
`ifdef DMEM_ARB_TIMEOUT_EN
    chk("to_done17", {31'd0, cpu_done}, 32'd1);
    chk("to_err17", {31'd0, cpu_err}, 32'd1);
    chk("to_rdata17", cpu_rdata, 32'd0);
    chk("to_idle17", {31'd0, busy}, 32'd0);
    @(negedge clk);
    cpu_addr = 32'h800;
    repeat (3) @(negedge clk);
    #1;
`else
    repeat (3) @(negedge clk);
    #1;
    chk("nto_busy20", {31'd0, busy}, 32'd1);
    chk("nto_nodone20", {31'd0, cpu_done}, 32'd0);
`endif

    // asynchronous reset mid-BUSY
    chk("rstmid_pre_en", {31'd0, mem_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_cpu_done", {31'd0, cpu_done}, 32'd0);
    chk("rstmid_cpu_rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // a fresh request completes normally after reset
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h900; mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    #1;
    chk("post_mem_en", {31'd0, mem_en}, 32'd1);
    chk("post_mem_addr", mem_addr, 32'h900);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("post_done", {31'd0, cpu_done}, 32'd1);
    chk("post_rdata", cpu_rdata, 32'h55AA55AA);
    chk("post_err", {31'd0, cpu_err}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("post_idle", {30'd0, busy, cpu_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
